// File: rtl/xgmii_rx_fault_detect.sv
// XGMII RX link fault detector: counts local/remote fault Sequence ordered sets
// across both columns of each cycle and declares/clears the link fault status.
module xgmii_rx_fault_detect #(
    parameter int FAULT_SEQ_CNT  = 4,
    parameter int FAULT_CLR_COLS = 128
) (
    input  logic        clk_xgmii_rx,
    input  logic        reset_xgmii_rx_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic        status_local_fault_crx,
    output logic        status_remote_fault_crx
);

    localparam int SEQ_W = $clog2(FAULT_SEQ_CNT + 1);
    localparam int COL_W = $clog2(FAULT_CLR_COLS + 1);

    // T_NONE doubles as "OTHER column", "no last type" and "fault OK".
    typedef enum logic [1:0] {
        T_NONE = 2'd0,
        T_LF   = 2'd1,
        T_RF   = 2'd2
    } seq_type_e;

    typedef struct packed {
        seq_type_e        last_type;
        logic [SEQ_W-1:0] seq_cnt;
        logic [COL_W-1:0] col_cnt;
        seq_type_e        fault;
    } state_t;

    state_t    state_q, state_a, state_d;
    seq_type_e type_a, type_b;
    logic      lf_q, rf_q;

    function automatic seq_type_e classify(input logic [31:0] d, input logic [3:0] c);
        seq_type_e t;
        t = T_NONE;
        if (c == 4'b0001 && d[23:0] == 24'h00_009C) begin
            if (d[31:24] == 8'h01)      t = T_LF;
            else if (d[31:24] == 8'h02) t = T_RF;
        end
        return t;
    endfunction

    function automatic state_t step(input state_t s, input seq_type_e t);
        state_t n;
        n = s;
        if (t == T_NONE) begin
            if (s.col_cnt >= COL_W'(FAULT_CLR_COLS - 1)) begin
                n.col_cnt   = COL_W'(FAULT_CLR_COLS);
                n.seq_cnt   = '0;
                n.last_type = T_NONE;
                n.fault     = T_NONE;
            end else begin
                n.col_cnt = s.col_cnt + COL_W'(1);
            end
        end else if (t == s.last_type) begin
            n.col_cnt = '0;
            if (s.seq_cnt < SEQ_W'(FAULT_SEQ_CNT))
                n.seq_cnt = s.seq_cnt + SEQ_W'(1);
            if (n.seq_cnt == SEQ_W'(FAULT_SEQ_CNT))
                n.fault = t;
        end else begin
            // A new type restarts the count but leaves any declared fault standing.
            n.last_type = t;
            n.seq_cnt   = SEQ_W'(1);
            n.col_cnt   = '0;
        end
        return n;
    endfunction

    always_comb begin
        type_a  = classify(xgmii_rxd[31:0],  xgmii_rxc[3:0]);
        type_b  = classify(xgmii_rxd[63:32], xgmii_rxc[7:4]);
        state_a = step(state_q, type_a);
        state_d = step(state_a, type_b);
    end

    always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
        if (!reset_xgmii_rx_n) begin
            state_q <= '0;
            lf_q    <= 1'b0;
            rf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lf_q    <= (state_d.fault == T_LF);
            rf_q    <= (state_d.fault == T_RF);
        end
    end

    assign status_local_fault_crx  = lf_q;
    assign status_remote_fault_crx = rf_q;

endmodule

// File: tb/tb_xgmii_rx_fault_detect.sv
// Scoreboard bench for xgmii_rx_fault_detect: the driver queues the expected
// {local, remote} status per cycle and a monitor checks it after each edge.
module tb_xgmii_rx_fault_detect;

    localparam logic [63:0] IDLE_D   = 64'h07070707_07070707;
    localparam logic [7:0]  IDLE_C   = 8'hFF;
    localparam logic [63:0] LF2_D    = 64'h0100009C_0100009C;
    localparam logic [63:0] RF2_D    = 64'h0200009C_0200009C;
    localparam logic [63:0] MAL2_D   = 64'h0300009C_0300009C;
    localparam logic [7:0]  SEQ2_C   = 8'h11;
    localparam logic [63:0] LFA_D    = 64'h07070707_0100009C;
    localparam logic [63:0] RFA_D    = 64'h07070707_0200009C;
    localparam logic [7:0]  SEQA_C   = 8'hF1;
    localparam logic [63:0] IDLB_D   = 64'h0100009C_07070707;
    localparam logic [7:0]  IDLB_C   = 8'h1F;

    logic        clk;
    logic        rst_n;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        lf, rf;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] exp_q[$];
    string      name_q[$];

    xgmii_rx_fault_detect #(
        .FAULT_SEQ_CNT (4),
        .FAULT_CLR_COLS(128)
    ) dut (
        .clk_xgmii_rx           (clk),
        .reset_xgmii_rx_n       (rst_n),
        .xgmii_rxd              (rxd),
        .xgmii_rxc              (rxc),
        .status_local_fault_crx (lf),
        .status_remote_fault_crx(rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [63:0] d, input logic [7:0] c, input int n,
                         input logic elf, input logic erf, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            rxd   = d;
            rxc   = c;
            exp_q.push_back({elf, erf});
            name_q.push_back(name);
        end
    endtask

    task automatic reset_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            rxd   = IDLE_D;
            rxc   = IDLE_C;
            exp_q.push_back(2'b00);
            name_q.push_back(name);
        end
    endtask

    initial begin : monitor
        logic [1:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests_run++;
                if ({lf, rf} !== e) begin
                    tests_failed++;
                    $display("FAIL %s: got lf=%0b rf=%0b, expected lf=%0b rf=%0b",
                             nm, lf, rf, e[1], e[0]);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        rxd   = IDLE_D;
        rxc   = IDLE_C;

        reset_cycles(3, "reset");
        drive(IDLE_D, IDLE_C, 200, 0, 0, "idle");

        // Local fault on both columns: declared after the 4th LF column.
        drive(LF2_D, SEQ2_C, 1, 0, 0, "lf_cycle1");
        drive(LF2_D, SEQ2_C, 1, 1, 0, "lf_cycle2");
        drive(LF2_D, SEQ2_C, 2, 1, 0, "lf_hold");

        // Clear: 127 OTHER columns hold, the 128th clears.
        drive(IDLE_D, IDLE_C, 63, 1, 0, "clr_before");
        drive(IDLE_D, IDLE_C, 1, 0, 0, "clr_at_128");

        // Remote fault in column A with 10-cycle gaps.
        for (int k = 0; k < 3; k++) begin
            drive(RFA_D, SEQA_C, 1, 0, 0, "rf_gap10_seq");
            drive(IDLE_D, IDLE_C, 10, 0, 0, "rf_gap10_idle");
        end
        drive(RFA_D, SEQA_C, 1, 0, 1, "rf_gap10_4th");
        drive(IDLE_D, IDLE_C, 63, 0, 1, "rf_clr_before");
        drive(IDLE_D, IDLE_C, 1, 0, 0, "rf_clr_at_128");

        // Gaps of 64 cycles clear the count each time.
        for (int k = 0; k < 4; k++) begin
            drive(RFA_D, SEQA_C, 1, 0, 0, "rf_gap64_seq");
            drive(IDLE_D, IDLE_C, 64, 0, 0, "rf_gap64_idle");
        end

        // Type switch from a declared local fault.
        drive(LF2_D, SEQ2_C, 1, 0, 0, "sw_lf1");
        drive(LF2_D, SEQ2_C, 1, 1, 0, "sw_lf2");
        drive(RF2_D, SEQ2_C, 1, 1, 0, "sw_rf2cols");
        drive(RFA_D, SEQA_C, 1, 1, 0, "sw_rf3rd");
        drive(IDLE_D, IDLE_C, 10, 1, 0, "sw_idle");
        drive(RFA_D, SEQA_C, 1, 0, 1, "sw_rf4th");
        drive(IDLE_D, IDLE_C, 63, 0, 1, "sw_clr_before");
        drive(IDLE_D, IDLE_C, 1, 0, 0, "sw_clr_at_128");

        // Reset mid-sequence discards the partial count.
        drive(LF2_D, SEQ2_C, 1, 0, 0, "rst_lf2");
        drive(LFA_D, SEQA_C, 1, 0, 0, "rst_lf3");
        reset_cycles(1, "rst_pulse");
        drive(LFA_D, SEQA_C, 1, 0, 0, "rst_lf_after");
        drive(IDLE_D, IDLE_C, 5, 0, 0, "rst_idle");

        // Malformed 0x9C sets count as OTHER toward the clear timeout.
        drive(LF2_D, SEQ2_C, 1, 0, 0, "mal_lf_a");
        drive(LF2_D, SEQ2_C, 1, 1, 0, "mal_lf_b");
        drive(MAL2_D, SEQ2_C, 63, 1, 0, "mal_before");
        drive(MAL2_D, SEQ2_C, 1, 0, 0, "mal_at_128");

        // Column A hits the clear threshold while column B starts a new LF count.
        drive(LF2_D, SEQ2_C, 1, 0, 0, "sim_lf_a");
        drive(LF2_D, SEQ2_C, 1, 1, 0, "sim_lf_b");
        drive(LFA_D, SEQA_C, 1, 1, 0, "sim_lf_sat");
        drive(IDLE_D, IDLE_C, 63, 1, 0, "sim_idle");
        drive(IDLB_D, IDLB_C, 1, 0, 0, "sim_clr_then_lf");
        drive(LF2_D, SEQ2_C, 1, 0, 0, "sim_lf_cnt3");
        drive(LFA_D, SEQA_C, 1, 1, 0, "sim_lf_cnt4");

        // A=LF, B=RF: LF abandoned, RF starts at 1 while LF fault persists.
        drive(64'h0200009C_0100009C, SEQ2_C, 1, 1, 0, "mix_lf_rf");
        drive(RF2_D, SEQ2_C, 1, 1, 0, "mix_rf3");
        drive(RFA_D, SEQA_C, 1, 0, 1, "mix_rf4");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d checks pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
